// File: rtl/sub_nbit_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
// Used by sub_nbit_ncc, whose optional floor-at-zero build is SUB_NBIT_SATURATE_EN.
package sub_nbit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sub_state_e;

  // Number of W-bit digits in an (n+1)-bit minuend: ceil((n+1)/w)
  function automatic int ncyc(input int n, input int w);
    return (n + w) / w;
  endfunction

  function automatic int cnt_w(input int n, input int w);
    return $clog2(ncyc(n, w) + 1);
  endfunction

endpackage

// File: rtl/sub_wbit_chunk.sv
// Combinational W-bit subtract-with-borrow: {bout, d} = a - b - bin.
module sub_wbit_chunk #(
  parameter int W = 2
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_bin,
  output logic [W-1:0] o_d,
  output logic         o_bout
);

  logic [W:0] w_diff;

  // One extra bit: a negative result wraps, so its top bit is the borrow out.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, i_bin};
  assign o_d    = w_diff[W-1:0];
  assign o_bout = w_diff[W];

endmodule

// File: rtl/sub_nbit_ncc.sv
// Digit-serial subtractor: d = o_input - g_input, W bits per clock over NCYC cycles.
// Define SUB_NBIT_SATURATE_EN to floor d at zero whenever the final borrow is set.
//
// state  | meaning
// S_IDLE | waiting for start; operands captured on the start edge
// S_RUN  | one digit per clock, LSB first, borrow carried between digits
// S_DONE | one-cycle done pulse; start here launches the next operation
module sub_nbit_ncc
  import sub_nbit_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N:0]   o_input,
  input  logic [N-1:0] g_input,
  output logic         busy,
  output logic         done,
  output logic [N:0]   d,
  output logic         borrow
);

  localparam int NCYC = ncyc(N, W);
  localparam int PW   = NCYC * W;
  localparam int CW   = cnt_w(N, W);
  localparam int DW   = N + 1;

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  sub_state_e    r_state;
  sub_state_e    w_state_nxt;
  logic [PW-1:0] r_a;
  logic [PW-1:0] r_b;
  logic [PW-1:0] r_res;
  logic [PW-1:0] w_res_nxt;
  logic          r_bor;
  logic [CW-1:0] r_cnt;
  logic          w_last;
  logic          w_load;
  logic          w_step;
  logic [W-1:0]  w_dig;
  logic          w_bo;
  logic [N:0]    w_d_fin;

  // Reset asserts immediately, releases two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  sub_wbit_chunk #(.W(W)) u_chunk (
    .i_a    (r_a[W-1:0]),
    .i_b    (r_b[W-1:0]),
    .i_bin  (r_bor),
    .o_d    (w_dig),
    .o_bout (w_bo)
  );

  assign w_last    = (r_cnt == CW'(NCYC - 1));
  assign w_res_nxt = (r_res >> W) | (PW'(w_dig) << (PW - W));

`ifdef SUB_NBIT_SATURATE_EN
  assign w_d_fin = w_bo ? '0 : DW'(w_res_nxt);
`else
  assign w_d_fin = DW'(w_res_nxt);
`endif

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result lands on the final digit edge so it is already valid while done is high.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_bor  <= 1'b0;
      r_cnt  <= '0;
      d      <= '0;
      borrow <= 1'b0;
    end else if (w_load) begin
      r_a   <= PW'(o_input);
      r_b   <= PW'(g_input);
      r_res <= '0;
      r_bor <= 1'b0;
      r_cnt <= '0;
    end else if (w_step) begin
      r_a   <= r_a >> W;
      r_b   <= r_b >> W;
      r_res <= w_res_nxt;
      r_bor <= w_bo;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        d      <= w_d_fin;
        borrow <= w_bo;
      end
    end
  end

endmodule

// File: tb/tb_sub_nbit_ncc.sv
// Directed bench for sub_nbit_ncc (N=8, W=2) plus a W sweep; honours SUB_NBIT_SATURATE_EN.
module tb_sub_nbit_ncc;

  typedef struct {
    logic [8:0] o;
    logic [7:0] g;
    logic [8:0] ed;
    logic       eb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] o_in = '0;
  logic [7:0] g_in = '0;
  logic       busy, done, borrow;
  logic [8:0] d;

  logic       s_start = 1'b0;
  logic [8:0] s_o = '0;
  logic [7:0] s_g = '0;
  logic [8:0] s_d [3];
  logic       s_b [3];
  logic       s_busy [3];
  logic       s_done [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sub_nbit_ncc #(.N(8), .W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .o_input(o_in), .g_input(g_in),
    .busy(busy), .done(done), .d(d), .borrow(borrow)
  );

  sub_nbit_ncc #(.N(8), .W(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .o_input(s_o), .g_input(s_g),
    .busy(s_busy[0]), .done(s_done[0]), .d(s_d[0]), .borrow(s_b[0])
  );

  sub_nbit_ncc #(.N(8), .W(3)) dut_w3 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .o_input(s_o), .g_input(s_g),
    .busy(s_busy[1]), .done(s_done[1]), .d(s_d[1]), .borrow(s_b[1])
  );

  sub_nbit_ncc #(.N(8), .W(9)) dut_w9 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .o_input(s_o), .g_input(s_g),
    .busy(s_busy[2]), .done(s_done[2]), .d(s_d[2]), .borrow(s_b[2])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Returns {borrow, d} for the active build.
  function automatic logic [9:0] model(input logic [8:0] o, input logic [7:0] g);
    logic [9:0] r;
    r = {1'b0, o} - {2'b00, g};
`ifdef SUB_NBIT_SATURATE_EN
    if (r[9]) r[8:0] = '0;
`endif
    return r;
  endfunction

  // Leaves the caller at the falling edge just after the start-sampling edge E0.
  task automatic start_op(input logic [8:0] o, input logic [7:0] g);
    @(negedge clk);
    o_in  = o;
    g_in  = g;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!done && edges < 30);
  endtask

  initial begin
    vec_t vecs [4];
    int   e, e2;
    logic seen;
    logic [9:0] m;

    vecs[0] = '{o: 9'h124, g: 8'hA9, ed: 9'h07B, eb: 1'b0};
    vecs[1] = '{o: 9'h111, g: 8'h74, ed: 9'h09D, eb: 1'b0};
    vecs[2] = '{o: 9'h1FE, g: 8'hFF, ed: 9'h0FF, eb: 1'b0};
`ifdef SUB_NBIT_SATURATE_EN
    vecs[3] = '{o: 9'h005, g: 8'h10, ed: 9'h000, eb: 1'b1};
`else
    vecs[3] = '{o: 9'h005, g: 8'h10, ed: 9'h1F5, eb: 1'b1};
`endif

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      start_op(vecs[i].o, vecs[i].g);
      chk($sformatf("v%0d_busy_run", i), 32'(busy), 32'd1);
      wait_done(e);
      chk($sformatf("v%0d_latency", i), 32'(e), 32'd5);
      chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_d", i), 32'(d), 32'(vecs[i].ed));
      chk($sformatf("v%0d_borrow", i), 32'(borrow), 32'(vecs[i].eb));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_d_held", i), 32'(d), 32'(vecs[i].ed));
    end

    // Back-to-back: start held during the done cycle
    start_op(9'h1FE, 8'hFF);
    wait_done(e);
    chk("b2b_first_d", 32'(d), 32'h0FF);
    o_in  = 9'h124;
    g_in  = 8'hA9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_d_held", 32'(d), 32'h0FF);
    wait_done(e2);
    chk("b2b_gap", 32'(e2 + 1), 32'd6);
    chk("b2b_second_d", 32'(d), 32'h07B);
    chk("b2b_second_borrow", 32'(borrow), 32'd0);

    // Start and operand changes mid-run are ignored
    start_op(9'h124, 8'hA9);
    @(posedge clk);
    @(negedge clk);
    o_in  = '0;
    g_in  = '0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(e);
    chk("ign_latency", 32'(e + 2), 32'd5);
    chk("ign_d", 32'(d), 32'h07B);

    // Reset mid-run aborts with no done pulse
    start_op(9'h124, 8'hA9);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_d", 32'(d), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    start_op(9'h111, 8'h74);
    wait_done(e);
    chk("rerun_latency", 32'(e), 32'd5);
    chk("rerun_d", 32'(d), 32'h09D);
    chk("rerun_borrow", 32'(borrow), 32'd0);

    // W sweep against the reference model
    for (int it = 0; it < 8; it++) begin
      @(negedge clk);
      if (it == 0) begin
        s_o = 9'h000; s_g = 8'hFF;
      end else if (it == 1) begin
        s_o = 9'h1FF; s_g = 8'h00;
      end else begin
        s_o = 9'($urandom_range(0, 511));
        s_g = 8'($urandom_range(0, 255));
      end
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      repeat (14) @(negedge clk);
      m = model(s_o, s_g);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("sweep%0d_inst%0d_d", it, k), 32'(s_d[k]), 32'(m[8:0]));
        chk($sformatf("sweep%0d_inst%0d_borrow", it, k), 32'(s_b[k]), 32'(m[9]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
